// File: rtl/des_key_sched_if.sv
// Handshake bundle for the DES key-schedule generator. The consumer/driver side
// uses the master modport, and the schedule core uses the slave modport.
interface des_key_sched_if;
    logic        i_start;
    logic [63:0] i_key;
    logic        i_decrypt;
    logic        i_subkey_ready;
    logic [47:0] o_subkey;
    logic        o_subkey_valid;
    logic [3:0]  o_round;
    logic        o_busy;
    logic        o_done;
    logic        o_parity_err;

    modport master (
        output i_start, i_key, i_decrypt, i_subkey_ready,
        input  o_subkey, o_subkey_valid, o_round, o_busy, o_done, o_parity_err
    );

    modport slave (
        input  i_start, i_key, i_decrypt, i_subkey_ready,
        output o_subkey, o_subkey_valid, o_round, o_busy, o_done, o_parity_err
    );
endinterface

// File: rtl/des_key_sched.sv
// Sequential DES key schedule: issues K1..K16 (encrypt) or K16..K1 (decrypt),
// one 48-bit subkey per valid/ready handshake.
module des_key_sched #(
    parameter bit CHECK_PARITY = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    des_key_sched_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit s set means the rotation for schedule index s is 2, otherwise 1.
    localparam logic [15:0] SHIFT_TWO = 16'b0111_1110_1111_1100;

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic [3:0]  step_q, step_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;
    logic        perr_q, perr_d;

    logic [55:0] pc1_key;
    logic [55:0] cd;
    logic [47:0] subkey;
    logic [7:0]  byte_even;
    logic        key_perr;

    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // DES bit n (1-based, MSB first) lives at vector index 64-n / 56-n.
    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign pc1_key[55-g] = bus.i_key[64-PC1[g]];
    end

    assign cd = {c_q, d_q};

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign subkey[47-g] = cd[56-PC2[g]];
    end

    for (genvar g = 0; g < 8; g++) begin : g_par
        assign byte_even[g] = ~^bus.i_key[8*g +: 8];
    end

    assign key_perr = CHECK_PARITY ? |byte_even : 1'b0;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        step_d  = step_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = ISSUE;
                    dec_d   = bus.i_decrypt;
                    perr_d  = key_perr;
                    step_d  = '0;
                    if (bus.i_decrypt) begin
                        c_d     = pc1_key[55:28];
                        d_d     = pc1_key[27:0];
                        round_d = 4'd15;
                    end else begin
                        c_d     = rot_l(pc1_key[55:28], SHIFT_TWO[0]);
                        d_d     = rot_l(pc1_key[27:0], SHIFT_TWO[0]);
                        round_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (bus.i_subkey_ready) begin
                    step_d = step_q + 4'd1;
                    // Decrypt also rotates on the last accept so {C,D} returns
                    // to PC-1(key); encrypt is already back there after K16.
                    if (dec_q) begin
                        c_d = rot_r(c_q, SHIFT_TWO[~step_q]);
                        d_d = rot_r(d_q, SHIFT_TWO[~step_q]);
                        if (step_q != 4'd15) begin
                            round_d = round_q - 4'd1;
                        end
                    end else if (step_q != 4'd15) begin
                        c_d     = rot_l(c_q, SHIFT_TWO[step_q + 4'd1]);
                        d_d     = rot_l(d_q, SHIFT_TWO[step_q + 4'd1]);
                        round_d = round_q + 4'd1;
                    end
                    if (step_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            step_q  <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            step_q  <= step_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.o_subkey       = subkey;
    assign bus.o_subkey_valid = (state_q == ISSUE);
    assign bus.o_busy         = (state_q == ISSUE);
    assign bus.o_round        = round_q;
    assign bus.o_done         = done_q;
    assign bus.o_parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Randomised scoreboard bench for des_key_sched; expected subkeys come from a
// table-driven model using cumulative rotation amounts.
module tb_des_key_sched;

    typedef struct packed {
        logic [3:0]  rnd;
        logic [47:0] sk;
    } exp_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KAT_KEY = 64'h1334_5779_9BBC_DFF1;

    logic clk;
    logic rst_n;
    des_key_sched_if bus ();

    des_key_sched #(.CHECK_PARITY(1'b1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          checks;
    int          errors;
    exp_t        exp_q[$];
    bit          ready_bp;
    bit          prev_final;
    int          acc_cnt;
    logic [47:0] first_sk;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: subkey r is PC-2 of PC-1 halves rotated by the running
    // sum of SHIFTS[0..r]; decrypt simply presents the same list reversed.
    task automatic model_push(input logic [63:0] key, input bit dec,
                              output logic [47:0] k16, output bit perr);
        logic [1:64] k;
        logic [1:28] c0, d0, c, d;
        logic [1:56] cdm;
        logic [1:48] ks;
        logic [47:0] subs [16];
        int          tot;
        exp_t        e;
        k   = key;
        tot = 0;
        for (int j = 1; j <= 28; j++) begin
            c0[j] = k[PC1[j-1]];
            d0[j] = k[PC1[j+27]];
        end
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            for (int j = 1; j <= 28; j++) begin
                c[j] = c0[((j - 1 + tot) % 28) + 1];
                d[j] = d0[((j - 1 + tot) % 28) + 1];
            end
            cdm = {c, d};
            for (int j = 1; j <= 48; j++) ks[j] = cdm[PC2[j-1]];
            subs[r] = ks;
        end
        for (int n = 0; n < 16; n++) begin
            e.rnd = dec ? 4'(15 - n) : 4'(n);
            e.sk  = subs[e.rnd];
            exp_q.push_back(e);
        end
        k16  = subs[15];
        perr = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if ($countones(key[8*b +: 8]) % 2 == 0) perr = 1'b1;
        end
    endtask

    initial begin
        bus.i_subkey_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_subkey_ready = ready_bp ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    // Monitor: every valid cycle must show the queue head; pop on handshake.
    initial begin
        prev_final = 1'b0;
        acc_cnt    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_final = 1'b0;
                acc_cnt    = 0;
            end else begin
                chk("done_pulse", 64'(bus.o_done), 64'(prev_final));
                prev_final = 1'b0;
                if (bus.o_subkey_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got round %0d subkey %0h expected no output",
                                 bus.o_round, bus.o_subkey);
                    end else begin
                        chk("round", 64'(bus.o_round), 64'(exp_q[0].rnd));
                        chk("subkey", 64'(bus.o_subkey), 64'(exp_q[0].sk));
                        if (bus.i_subkey_ready) begin
                            void'(exp_q.pop_front());
                            acc_cnt++;
                            if (acc_cnt == 16) begin
                                prev_final = 1'b1;
                                acc_cnt    = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic run_sched(input logic [63:0] key, input bit dec, input bit bp,
                             input bit inj5, input bit start_final, input bit rst8);
        logic [47:0] k16;
        bit          perr;
        int          cyc;
        bit          injected;
        bit          got_done;
        ready_bp = bp;
        model_push(key, dec, k16, perr);
        @(posedge clk);
        #1;
        chk("idle_before_start", 64'(bus.o_subkey_valid), 64'(0));
        bus.i_start   = 1'b1;
        bus.i_key     = key;
        bus.i_decrypt = dec;
        @(posedge clk);
        #1;
        bus.i_start   = 1'b0;
        bus.i_key     = {$urandom, $urandom};
        bus.i_decrypt = 1'($urandom_range(0, 1));
        chk("valid_latency", 64'(bus.o_subkey_valid), 64'(1));
        chk("first_round", 64'(bus.o_round), dec ? 64'(15) : 64'(0));
        chk("parity_err", 64'(bus.o_parity_err), 64'(perr));
        first_sk = bus.o_subkey;
        cyc      = 0;
        injected = 1'b0;
        got_done = 1'b0;
        while (!got_done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.i_start = 1'b0;
            if (bus.o_done) begin
                got_done = 1'b1;
            end else if (rst8 && bus.o_round == 4'd8) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_valid", 64'(bus.o_subkey_valid), 64'(0));
                chk("rst_busy", 64'(bus.o_busy), 64'(0));
                chk("rst_round", 64'(bus.o_round), 64'(0));
                chk("rst_subkey", 64'(bus.o_subkey), 64'(0));
                chk("rst_parity", 64'(bus.o_parity_err), 64'(0));
                exp_q.delete();
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    chk("rst_no_done", 64'(bus.o_done), 64'(0));
                end
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                chk("post_rst_no_done", 64'(bus.o_done), 64'(0));
                return;
            end else if (inj5 && !injected && bus.o_round == 4'd5) begin
                injected      = 1'b1;
                bus.i_start   = 1'b1;
                bus.i_key     = '0;
                bus.i_decrypt = ~dec;
            end else if (start_final && bus.o_round == (dec ? 4'd0 : 4'd15)) begin
                bus.i_start = 1'b1;
                bus.i_key   = {$urandom, $urandom};
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no o_done within %0d cycles, required one", cyc);
            return;
        end
        chk("done_valid_low", 64'(bus.o_subkey_valid), 64'(0));
        chk("done_busy_low", 64'(bus.o_busy), 64'(0));
        chk("final_round", 64'(bus.o_round), dec ? 64'(0) : 64'(15));
        chk("final_subkey", 64'(bus.o_subkey), 64'(k16));
        chk("parity_hold", 64'(bus.o_parity_err), 64'(perr));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        if (!bp && !inj5) chk("b2b_cycles", 64'(cyc), 64'(16));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        ready_bp      = 1'b0;
        rst_n         = 1'b0;
        bus.i_start   = 1'b0;
        bus.i_key     = '0;
        bus.i_decrypt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(bus.o_subkey_valid), 64'(0));
        chk("reset_busy", 64'(bus.o_busy), 64'(0));
        chk("reset_done", 64'(bus.o_done), 64'(0));
        chk("reset_round", 64'(bus.o_round), 64'(0));
        chk("reset_subkey", 64'(bus.o_subkey), 64'(0));
        chk("reset_parity", 64'(bus.o_parity_err), 64'(0));
        rst_n = 1'b1;

        run_sched(KAT_KEY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("kat_enc_first", 64'(first_sk), 64'h1B02_EFFC_7072);
        chk("kat_enc_end", 64'(bus.o_subkey), 64'hCB3D_8B0E_17F5);
        run_sched(KAT_KEY, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("kat_dec_first", 64'(first_sk), 64'hCB3D_8B0E_17F5);
        run_sched(KAT_KEY, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_sched({$urandom, $urandom}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_sched({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_sched({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_sched({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_sched({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        run_sched(64'h0101_0101_0101_0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("weak_zero_first", 64'(first_sk), 64'h0);
        chk("weak_zero_parity", 64'(bus.o_parity_err), 64'(0));
        run_sched(64'h0001_0101_0101_0101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bad_parity_flag", 64'(bus.o_parity_err), 64'(1));
        run_sched(64'hFEFE_FEFE_FEFE_FEFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("weak_ones_first", 64'(first_sk), 64'hFFFF_FFFF_FFFF);

        for (int i = 0; i < 6; i++) begin
            run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
